// File: rtl/systolic_array_nxm.sv
// systolic_array_nxm: ROWS x COLS weight-stationary systolic array.
// Callers present aligned input vectors and receive aligned output vectors;
// input skew and output deskew are handled internally. Weights are loaded
// bottom row first through a ready/valid port into a shadow bank. A switch
// token then moves them into the active bank, one PE per cycle in a wavefront,
// so that every result is computed entirely with old or entirely with new weights.
// Ports:
//   clk, rst                          clock, async active-high reset
//   cfg_col_size_valid, cfg_col_size  enable the lowest cfg_col_size columns
//                                     (values above COLS saturate to COLS)
//   w_valid, w_ready, w_data          weight row beats, bottom row first
//   w_loaded                          one-cycle pulse in the shadow->active swap cycle
//   x_valid, x_data                   aligned input vector, no backpressure
//   y_valid, y_data                   aligned output vector, ROWS+COLS-1 cycles later
//   busy                              vectors or switch token in flight, or load active
module systolic_array_nxm #(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned DATA_W = 16,
   localparam int unsigned CSW   = $clog2(COLS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_col_size_valid,
   input  logic [CSW-1:0]           cfg_col_size,
   input  logic                     w_valid,
   output logic                     w_ready,
   input  logic [COLS*DATA_W-1:0]   w_data,
   output logic                     w_loaded,
   input  logic                     x_valid,
   input  logic [ROWS*DATA_W-1:0]   x_data,
   output logic                     y_valid,
   output logic [COLS*DATA_W-1:0]   y_data,
   output logic                     busy
);

   localparam int unsigned LAT   = ROWS + COLS - 1;
   localparam int unsigned CNT_W = $clog2(ROWS + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_SWAP} state_t;

   state_t                 state, state_d;
   logic [CNT_W-1:0]       cnt, cnt_d;
   logic [COLS-1:0]        mask;
   logic [DATA_W-1:0]      ws  [ROWS][COLS];
   logic [DATA_W-1:0]      xs  [ROWS];
   logic [DATA_W-1:0]      x_q [ROWS][COLS];
   logic [DATA_W-1:0]      p_q [ROWS][COLS];
   logic [ROWS*COLS-1:0]   tok_q, tok_in;
   logic [LAT-1:0]         vpipe, vpipe_d;
   logic                   accept, launch, tok_busy, tok_busy_d;

   assign accept     = w_valid && w_ready;
   assign launch     = (state == S_SWAP);
   assign tok_busy   = |tok_q;
   assign tok_busy_d = |tok_in;
   assign y_valid    = vpipe[LAT-1];

   // Column enable mask, saturating at COLS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask <= '0;
      end else if (cfg_col_size_valid) begin
         for (int c = 0; c < COLS; c++) mask[c] <= (CSW'(c) < cfg_col_size);
      end
   end

   // Shadow weights: each beat enters row 0 and pushes older rows down.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) ws[r][c] <= '0;
      end else if (accept) begin
         for (int c = 0; c < COLS; c++) ws[0][c] <= w_data[c*DATA_W +: DATA_W];
         for (int r = 1; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) ws[r][c] <= ws[r-1][c];
      end
   end

   // Input skew: row r delayed r cycles; idle slots carry zero.
   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      logic [DATA_W-1:0] xin;
      assign xin = x_valid ? x_data[r*DATA_W +: DATA_W] : '0;
      if (r == 0) begin : g_direct
         assign xs[r] = xin;
      end else begin : g_dly
         logic [DATA_W-1:0] sr [r];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < r; k++) sr[k] <= '0;
            end else begin
               sr[0] <= xin;
               for (int k = 1; k < r; k++) sr[k] <= sr[k-1];
            end
         end
         assign xs[r] = sr[r-1];
      end
   end

   // PE grid; the switch token runs right along rows, and down column 0.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_pe
         logic [DATA_W-1:0] x_in, p_in, w_act, x_r, p_r;
         logic              t_in, t_r;

         if (c == 0) begin : g_xl
            assign x_in = xs[r];
         end else begin : g_xp
            assign x_in = x_q[r][c-1];
         end
         if (r == 0) begin : g_pt
            assign p_in = '0;
         end else begin : g_pp
            assign p_in = p_q[r-1][c];
         end
         if (r == 0 && c == 0) begin : g_t0
            assign t_in = launch;
         end else if (c == 0) begin : g_tu
            assign t_in = tok_q[(r-1)*COLS];
         end else begin : g_tl
            assign t_in = tok_q[r*COLS + c - 1];
         end

         // The MAC in the token cycle still uses the old weight.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               x_r   <= '0;
               p_r   <= '0;
               w_act <= '0;
               t_r   <= 1'b0;
            end else begin
               t_r <= t_in;
               if (t_in) w_act <= ws[r][c];
               if (mask[c]) begin
                  x_r <= x_in;
                  p_r <= p_in + x_in * w_act;
               end else begin
                  x_r <= '0;
                  p_r <= '0;
               end
            end
         end

         assign x_q[r][c]           = x_r;
         assign p_q[r][c]           = p_r;
         assign tok_q[r*COLS + c]   = t_r;
         assign tok_in[r*COLS + c]  = t_in;
      end
   end

   // Output deskew: column c delayed COLS-1-c cycles.
   for (genvar c = 0; c < COLS; c++) begin : g_dsk
      localparam int unsigned D = COLS - 1 - c;
      if (D == 0) begin : g_direct
         assign y_data[c*DATA_W +: DATA_W] = p_q[ROWS-1][c];
      end else begin : g_dly
         logic [DATA_W-1:0] dr [D];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < D; k++) dr[k] <= '0;
            end else begin
               dr[0] <= p_q[ROWS-1][c];
               for (int k = 1; k < D; k++) dr[k] <= dr[k-1];
            end
         end
         assign y_data[c*DATA_W +: DATA_W] = dr[D-1];
      end
   end

   // Valid tracking across skew, grid and deskew.
   always_comb begin
      vpipe_d = LAT'({vpipe, x_valid});
   end

   // Weight-load FSM next state.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               cnt_d = (state == S_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
               if (cnt_d == CNT_W'(ROWS)) state_d = tok_busy ? S_HOLD : S_SWAP;
               else                       state_d = S_LOAD;
            end
         end
         S_HOLD: begin
            if (!tok_busy) state_d = S_SWAP;
         end
         S_SWAP: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         vpipe    <= '0;
         w_ready  <= 1'b1;
         w_loaded <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         vpipe    <= vpipe_d;
         w_ready  <= (state_d == S_IDLE) || (state_d == S_LOAD);
         w_loaded <= (state_d == S_SWAP);
         busy     <= (state_d != S_IDLE) || (|vpipe_d) || tok_busy_d;
      end
   end

endmodule

// File: tb/tb_systolic_array_nxm.sv
// tb_systolic_array_nxm: directed and random stimulus for systolic_array_nxm
// (4x4, 16-bit), checked against a matrix-vector reference model.
module tb_systolic_array_nxm;
   localparam int R = 4, C = 4, DW = 16, LAT = R + C - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_col_size_valid;
   logic [2:0]    cfg_col_size;
   logic          w_valid, w_ready, w_loaded;
   logic [63:0]   w_data;
   logic          x_valid;
   logic [63:0]   x_data;
   logic          y_valid;
   logic [63:0]   y_data;
   logic          busy;

   systolic_array_nxm #(.ROWS(R), .COLS(C), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .cfg_col_size_valid(cfg_col_size_valid), .cfg_col_size(cfg_col_size),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_loaded(w_loaded),
      .x_valid(x_valid), .x_data(x_data),
      .y_valid(y_valid), .y_data(y_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: shadow/active weight matrices, mask, expected results.
   typedef struct { int due; logic [63:0] y; } exp_t;
   exp_t            q[$];
   exp_t            hd;
   logic [DW-1:0]   sh  [R][C];
   logic [DW-1:0]   act [R][C];
   logic [C-1:0]    msk;
   int              cyc;

   function automatic logic [63:0] ref_y(input logic [63:0] x);
      logic [63:0]   y;
      logic [DW-1:0] acc;
      y = '0;
      for (int c = 0; c < C; c++) begin
         acc = '0;
         for (int r = 0; r < R; r++) acc += x[r*DW +: DW] * act[r][c];
         if (msk[c]) y[c*DW +: DW] = acc;
      end
      return y;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
               sh[r][c]  = '0;
               act[r][c] = '0;
            end
         msk = '0;
         cyc = 0;
      end else begin
         cyc++;
         if (q.size() > 0 && q[0].due == cyc) begin
            hd = q.pop_front();
            check("y_valid", 64'(y_valid), 64'd1);
            check("y_data", y_data, hd.y);
         end else begin
            check("y_idle", 64'(y_valid), 64'd0);
         end
         if (x_valid) q.push_back('{cyc + LAT, ref_y(x_data)});
         if (w_valid && w_ready) begin
            for (int r = R - 1; r > 0; r--)
               for (int c = 0; c < C; c++) sh[r][c] = sh[r-1][c];
            for (int c = 0; c < C; c++) sh[0][c] = w_data[c*DW +: DW];
         end
         if (w_loaded) act = sh;
         if (cfg_col_size_valid)
            for (int c = 0; c < C; c++) msk[c] = (c < int'(cfg_col_size));
      end
   end

   logic [63:0] wm [R];
   logic [63:0] bt [8];
   logic [63:0] y;
   int          n, k, idx, pulses, p0, p1;
   logic        acc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [2:0] v);
      cfg_col_size_valid = 1'b1;
      cfg_col_size       = v;
      tick();
      cfg_col_size_valid = 1'b0;
   endtask

   task automatic send(input logic [63:0] x);
      x_valid = 1'b1;
      x_data  = x;
      tick();
      x_valid = 1'b0;
   endtask

   task automatic get_y(output logic [63:0] yo, output int no);
      no = 0;
      do begin
         @(negedge clk);
         no++;
      end while (!y_valid && no < 40);
      yo = y_data;
      tick();
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (busy && w < 200) begin
         tick();
         w++;
      end
      check("idle", 64'(busy), 64'd0);
   endtask

   // Sends wm bottom row first, then waits for the swap pulse.
   task automatic load();
      int w;
      for (int b = 0; b < R; b++) begin
         w_valid = 1'b1;
         w_data  = wm[R-1-b];
         w = 0;
         while (!w_ready && w < 50) begin
            tick();
            w++;
         end
         if (w == 50) check("load_ready", 64'(w_ready), 64'd1);
         tick();
      end
      w_valid = 1'b0;
      w = 0;
      while (!w_loaded && w < 20) begin
         tick();
         w++;
      end
      check("w_loaded", 64'(w_loaded), 64'd1);
   endtask

   task automatic rand_traffic(input int len);
      for (int i = 0; i < len; i++) begin
         x_valid = 1'($urandom % 2);
         x_data  = {$urandom, $urandom};
         tick();
      end
      x_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      rst = 1'b1;
      cfg_col_size_valid = 1'b0; cfg_col_size = '0;
      w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_w_ready", 64'(w_ready), 64'd1);
      check("rst_w_loaded", 64'(w_loaded), 64'd0);
      check("rst_y_valid", 64'(y_valid), 64'd0);
      check("rst_y_data", y_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick();
      cfg(3'd4);

      // Identity weights, exact latency.
      for (int r = 0; r < R; r++) begin
         wm[r] = '0;
         wm[r][r*DW +: DW] = 16'd1;
      end
      load();
      wait_idle();
      send(64'h0004_0003_0002_0001);
      get_y(y, n);
      check("ident_latency", 64'(n), 64'(LAT));
      check("ident_y", y, 64'h0004_0003_0002_0001);
      wait_idle();

      // Stream 8 vectors while loading 2*I; swap lands on vector 4.
      for (int r = 0; r < R; r++) begin
         wm[r] = '0;
         wm[r][r*DW +: DW] = 16'd2;
      end
      for (int i = 0; i < 9; i++) begin
         if (i == R) check("stream_swap", 64'(w_loaded), 64'd1);
         w_valid = (i < R);
         if (i < R) w_data = wm[R-1-i];
         x_valid = (i >= 1);
         x_data  = {$urandom, $urandom};
         tick();
      end
      w_valid = 1'b0;
      x_valid = 1'b0;
      wait_idle();

      // Column enable with all-ones weights.
      for (int r = 0; r < R; r++) wm[r] = {4{16'h0001}};
      load();
      wait_idle();
      cfg(3'd2);
      send({4{16'h0001}});
      get_y(y, n);
      check("mask2_y", y, 64'h0000_0000_0004_0004);
      wait_idle();
      cfg(3'd7);
      send({4{16'h0001}});
      get_y(y, n);
      check("mask7_y", y, 64'h0004_0004_0004_0004);
      wait_idle();

      // Wrap-around arithmetic.
      for (int r = 0; r < R; r++) wm[r] = '0;
      wm[0][15:0] = 16'h7FFF;
      load();
      wait_idle();
      send(64'h0000_0000_0000_0002);
      get_y(y, n);
      check("wrap_pos", 64'(y[15:0]), 64'h0000_0000_0000_FFFE);
      wait_idle();
      wm[0][15:0] = 16'hFFFF;
      load();
      wait_idle();
      send(64'h0000_0000_0000_0003);
      get_y(y, n);
      check("wrap_neg", 64'(y[15:0]), 64'h0000_0000_0000_FFFD);
      wait_idle();

      // Random weights, column sizes and vector streams.
      for (int rnd = 0; rnd < 4; rnd++) begin
         for (int r = 0; r < R; r++) wm[r] = {$urandom, $urandom};
         load();
         wait_idle();
         cfg(3'($urandom_range(0, 7)));
         rand_traffic(24);
      end
      cfg(3'd4);

      // Back-to-back loads with w_valid held high.
      for (int b = 0; b < 8; b++) bt[b] = {$urandom, $urandom};
      idx = 0; pulses = 0; p0 = 0; p1 = 0; k = 0;
      while ((idx < 8 || pulses < 2) && k < 60) begin
         w_valid = (idx < 8);
         w_data  = bt[(idx < 8) ? idx : 7];
         @(negedge clk);
         acc = w_valid && w_ready;
         if (w_loaded) begin
            if (pulses == 0) p0 = k;
            else             p1 = k;
            pulses++;
            check("swap_ready_low", 64'(w_ready), 64'd0);
         end
         @(posedge clk);
         #1;
         if (acc) idx++;
         k++;
      end
      w_valid = 1'b0;
      check("b2b_pulses", 64'(pulses), 64'd2);
      check("b2b_gap", 64'((p1 - p0) >= LAT), 64'd1);
      wait_idle();
      rand_traffic(16);

      // Reset mid-load with vectors in flight.
      w_valid = 1'b1; w_data = {$urandom, $urandom};
      tick();
      w_data = {$urandom, $urandom};
      x_valid = 1'b1; x_data = {$urandom, $urandom};
      tick();
      w_valid = 1'b0;
      x_data = {$urandom, $urandom};
      tick();
      rst = 1'b1;
      x_valid = 1'b0;
      #1;
      check("mid_rst_y_valid", 64'(y_valid), 64'd0);
      check("mid_rst_y_data", y_data, 64'd0);
      check("mid_rst_w_ready", 64'(w_ready), 64'd1);
      check("mid_rst_w_loaded", 64'(w_loaded), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      cfg(3'd4);
      send({$urandom, $urandom});
      get_y(y, n);
      check("post_rst_zero_w", y, 64'd0);
      wait_idle();
      for (int r = 0; r < R; r++) wm[r] = {$urandom, $urandom};
      load();
      wait_idle();
      rand_traffic(16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
